// File: rtl/sprw_result_fifo_pkg.sv
// Shared types for the Sparrow result FIFO: the SIMD word type, the buffered
// entry (result word plus op1 tag) and the default FIFO depth.
package sprw_result_fifo_pkg;

  typedef logic [31:0] sprw_word_t;

  typedef struct packed {
    sprw_word_t  data;
    logic [4:0]  tag;
  } sprw_res_entry_t;

  localparam int SPRW_RES_FIFO_DEPTH = 4;

  // Bundle a result word and its tag into one storage entry.
  function automatic sprw_res_entry_t sprw_res_pack(input sprw_word_t data,
                                                    input logic [4:0] tag);
    sprw_res_entry_t e;
    e.data = data;
    e.tag  = tag;
    return e;
  endfunction

endpackage

// File: rtl/sprw_result_fifo_if.sv
// Consumer-side valid/ready bus of the result FIFO. The FIFO is the master
// (drives valid and the two result halves), the sink is the slave.
interface sprw_result_fifo_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_lo;
  logic [15:0] out_hi;
  logic [4:0]  out_tag;

  modport master (output out_valid, output out_lo, output out_hi,
                  output out_tag, input out_ready);
  modport slave  (input out_valid, input out_lo, input out_hi,
                  input out_tag, output out_ready);
endinterface

// File: rtl/sprw_result_fifo_ptr.sv
// Wrap-bit read/write pointer pair for the result FIFO. Derives full/empty,
// occupancy and the sticky overflow flag. A push into a full FIFO is only
// accepted when a pop frees the head slot in the same cycle.
module sprw_result_fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  output logic                     o_write,
  output logic                     o_empty,
  output logic [$clog2(DEPTH)-1:0] o_wr_idx,
  output logic [$clog2(DEPTH)-1:0] o_rd_idx,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        r_ovf;
  logic        w_full;
  logic        w_read;

  assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_empty  = (r_wr == r_rd);
  assign o_write  = i_push & (~w_full | i_pop);
  assign w_read   = i_pop & ~o_empty;
  assign o_wr_idx = r_wr[AW-1:0];
  assign o_rd_idx = r_rd[AW-1:0];
  assign o_count  = r_wr - r_rd;
  assign o_ovf    = r_ovf;

  // Pointer advance and sticky overflow on a dropped push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (o_write) r_wr <= r_wr + (AW+1)'(1);
      if (w_read)  r_rd <= r_rd + (AW+1)'(1);
      if (i_push && w_full && !i_pop) r_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/sprw_result_fifo.sv
// Result FIFO behind the Sparrow SIMD unit: captures each written-back result
// with its op1 tag, presents it to the sink as two 16-bit halves over
// valid/ready, and raises stall_req before the buffer can overflow.
// Optional cut-through forwarding into an empty FIFO: SPRW_RES_FWD_EN.
module sprw_result_fifo
  import sprw_result_fifo_pkg::*;
#(
  parameter int DEPTH     = SPRW_RES_FIFO_DEPTH,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_holdn,
  input  logic                   i_res_we,
  input  sprw_word_t             i_res_data,
  input  logic [4:0]             i_res_tag,
  sprw_result_fifo_if.master     io_out,
  output logic                   o_stall_req,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sprw_res_entry_t r_mem [DEPTH];
  sprw_res_entry_t r_last;
  sprw_res_entry_t w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_fwd;
  logic            w_ptr_push;
  logic            w_write;
  logic            w_empty;
  logic            w_valid;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;

  assign w_push = i_res_we & i_holdn;
  assign w_pop  = w_valid & io_out.out_ready;

`ifdef SPRW_RES_FWD_EN
  assign w_fwd = w_empty & w_push;
`else
  assign w_fwd = 1'b0;
`endif

  // A forwarded entry consumed in the same cycle never touches the storage.
  assign w_ptr_push = w_push & ~(w_fwd & io_out.out_ready);

  sprw_result_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_ptr_push),
    .i_pop    (w_pop),
    .o_write  (w_write),
    .o_empty  (w_empty),
    .o_wr_idx (w_wr_idx),
    .o_rd_idx (w_rd_idx),
    .o_count  (o_count),
    .o_ovf    (o_ovf)
  );

  // Storage write; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[w_wr_idx] <= sprw_res_pack(i_res_data, i_res_tag);
  end

  // Last consumed entry, shown on the bus while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst)        r_last <= '0;
    else if (w_pop) r_last <= w_head;
  end

  // Head selection: stored head, last popped value, or the cut-through input.
  always_comb begin
    w_valid = ~w_empty;
    w_head  = w_empty ? r_last : r_mem[w_rd_idx];
    if (w_fwd) begin
      w_valid = 1'b1;
      w_head  = sprw_res_pack(i_res_data, i_res_tag);
    end
  end

  assign io_out.out_valid = w_valid;
  assign io_out.out_lo    = w_head.data[15:0];
  assign io_out.out_hi    = w_head.data[31:16];
  assign io_out.out_tag   = w_head.tag;
  assign o_stall_req      = (o_count >= CW'(AFULL_LVL));

endmodule

// File: tb/tb_sprw_result_fifo.sv
// Directed bench for sprw_result_fifo (DEPTH=4, stall threshold 3).
module tb_sprw_result_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        holdn;
  logic        res_we;
  logic [31:0] res_data;
  logic [4:0]  res_tag;
  logic        stall;
  logic [2:0]  count;
  logic        ovf;
  int          errors = 0;
  int          checks = 0;

  sprw_result_fifo_if bus ();

  sprw_result_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .i_holdn     (holdn),
    .i_res_we    (res_we),
    .i_res_data  (res_data),
    .i_res_tag   (res_tag),
    .io_out      (bus),
    .o_stall_req (stall),
    .o_count     (count),
    .o_ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] t);
    res_we = 1'b1; res_data = d; res_tag = t;
    tick();
    res_we = 1'b0;
  endtask

  task automatic test_reset();
    holdn = 1'b1; res_we = 1'b1; res_data = 32'h12345678; res_tag = 5'd3;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; res_we = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if ({bus.out_hi, bus.out_lo, bus.out_tag} !== 37'd0)
      begin errors++; $display("FAIL reset_out got=%h_%h_%h exp=0", bus.out_hi, bus.out_lo, bus.out_tag); end
  endtask

  task automatic test_fill();
    logic [31:0] w [4];
    logic [2:0]  exp_cnt;
    w[0] = 32'h00010002; w[1] = 32'h00030004; w[2] = 32'h00050006; w[3] = 32'h00070008;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(w[i], 5'(i + 1));
      exp_cnt = 3'(i + 1);
      checks++; if (count !== exp_cnt) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, exp_cnt); end
      checks++; if (stall !== (i >= 2)) begin errors++; $display("FAIL fill_stall[%0d] got=%b exp=%b", i, stall, (i >= 2)); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_lo !== 16'h0002 || bus.out_hi !== 16'h0001 || bus.out_tag !== 5'd1)
        begin errors++; $display("FAIL fill_head[%0d] got=%b %h %h %0d exp=1 0002 0001 1", i, bus.out_valid, bus.out_lo, bus.out_hi, bus.out_tag); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w [4];
    w[0] = 32'h00010002; w[1] = 32'h00030004; w[2] = 32'h00050006; w[3] = 32'h00070008;
    bus.out_ready = 1'b0;
    push(32'hDEADBEEF, 5'd9);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || {bus.out_hi, bus.out_lo} !== w[i] || bus.out_tag !== 5'(i + 1))
        begin errors++; $display("FAIL drain[%0d] got=%b %h%h %0d exp=1 %h %0d", i, bus.out_valid, bus.out_hi, bus.out_lo, bus.out_tag, w[i], i + 1); end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0d/%b exp=0/0", count, bus.out_valid); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    checks++; if ({bus.out_hi, bus.out_lo} !== 32'h00070008 || bus.out_tag !== 5'd4)
      begin errors++; $display("FAIL hold_last got=%h%h %0d exp=00070008 4", bus.out_hi, bus.out_lo, bus.out_tag); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] w [5];
    logic [4:0]  t [5];
    w[0] = 32'hA0000001; w[1] = 32'hA0000002; w[2] = 32'hA0000003; w[3] = 32'hA0000004; w[4] = 32'h11112222;
    t[0] = 5'd11; t[1] = 5'd12; t[2] = 5'd13; t[3] = 5'd14; t[4] = 5'd21;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(w[i], t[i]);
    bus.out_ready = 1'b1;
    push(w[4], t[4]);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL pp_count got=%0d exp=4", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL pp_ovf got=%b exp=0", ovf); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || {bus.out_hi, bus.out_lo} !== w[i] || bus.out_tag !== t[i])
        begin errors++; $display("FAIL pp_drain[%0d] got=%b %h%h %0d exp=1 %h %0d", i, bus.out_valid, bus.out_hi, bus.out_lo, bus.out_tag, w[i], t[i]); end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL pp_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_holdn();
    do_reset();
    bus.out_ready = 1'b0;
    push(32'h0BAD0001, 5'd5);
    push(32'h0BAD0002, 5'd6);
    holdn = 1'b0; res_we = 1'b1; res_data = 32'h55555555; res_tag = 5'd30;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL holdn_count[%0d] got=%0d exp=2", i, count); end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (count !== 3'd1 || {bus.out_hi, bus.out_lo} !== 32'h0BAD0002 || bus.out_tag !== 5'd6)
      begin errors++; $display("FAIL holdn_drain got=%0d %h%h %0d exp=1 0bad0002 6", count, bus.out_hi, bus.out_lo, bus.out_tag); end
    tick();
    checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL holdn_empty got=%0d/%b exp=0/0", count, bus.out_valid); end
    bus.out_ready = 1'b0; holdn = 1'b1; res_we = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h0F0F0000 + i, 5'(i));
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL mid_pre_ovf got=%b exp=1", ovf); end
    rst = 1'b1; res_we = 1'b1; res_data = 32'h77778888; res_tag = 5'd17;
    tick();
    rst = 1'b0; res_we = 1'b0;
    checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0 || ovf !== 1'b0 || stall !== 1'b0)
      begin errors++; $display("FAIL mid_reset_ctrl got=cnt%0d v%b o%b s%b exp=0 0 0 0", count, bus.out_valid, ovf, stall); end
    checks++; if ({bus.out_hi, bus.out_lo, bus.out_tag} !== 37'd0)
      begin errors++; $display("FAIL mid_reset_out got=%h_%h_%h exp=0", bus.out_hi, bus.out_lo, bus.out_tag); end
  endtask

  task automatic test_forward();
    do_reset();
    bus.out_ready = 1'b1;
    res_we = 1'b1; res_data = 32'hCAFE0001; res_tag = 5'd7;
    #1;
`ifdef SPRW_RES_FWD_EN
    checks++; if (bus.out_valid !== 1'b1 || bus.out_hi !== 16'hCAFE || bus.out_lo !== 16'h0001 || bus.out_tag !== 5'd7)
      begin errors++; $display("FAIL fwd_same got=%b %h %h %0d exp=1 cafe 0001 7", bus.out_valid, bus.out_hi, bus.out_lo, bus.out_tag); end
    tick();
    res_we = 1'b0;
    checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL fwd_count got=%0d/%b exp=0/0", count, bus.out_valid); end
    checks++; if ({bus.out_hi, bus.out_lo} !== 32'hCAFE0001) begin errors++; $display("FAIL fwd_last got=%h%h exp=cafe0001", bus.out_hi, bus.out_lo); end
`else
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL nofwd_same got=%b exp=0", bus.out_valid); end
    tick();
    res_we = 1'b0;
    checks++; if (count !== 3'd1 || bus.out_valid !== 1'b1 || bus.out_hi !== 16'hCAFE || bus.out_lo !== 16'h0001 || bus.out_tag !== 5'd7)
      begin errors++; $display("FAIL nofwd_next got=%0d %b %h %h %0d exp=1 1 cafe 0001 7", count, bus.out_valid, bus.out_hi, bus.out_lo, bus.out_tag); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL nofwd_pop got=%0d exp=0", count); end
`endif
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_push_pop();
    test_holdn();
    test_reset_midstream();
    test_forward();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
